// File: rtl/morse_tx_ctrl.sv
// morse_tx_ctrl
//   Morse transmitter controller for letters A-H. A rising edge on Start
//   latches the 12-bit code of Letter and shifts it out MSB first on
//   DotDashOut. Each bit lasts TICK_DIV clocks.
//
// Ports
//   ClockIn     in   system clock, rising edge
//   Reset       in   asynchronous active-high reset
//   Start       in   transmit request, rising-edge sensitive
//   Letter      in   3-bit letter select (0=A .. 7=H), sampled on accepted edge
//   DotDashOut  out  current Morse bit (1 = light on)
//   NewBitOut   out  one-cycle pulse on the first cycle of each bit
//   Busy        out  high while sending or in the final Done cycle
//   Done        out  one-cycle pulse after the last bit completes
module morse_tx_ctrl #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned NBITS    = 12
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic [2:0] Letter,
    output logic       DotDashOut,
    output logic       NewBitOut,
    output logic       Busy,
    output logic       Done
);

    localparam int unsigned      RateW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [RateW-1:0] RateMax = RateW'(TICK_DIV - 1);
    localparam logic [3:0]       LastBit = 4'(NBITS - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [RateW-1:0] rate_q, rate_d;
    logic [3:0]       bit_q, bit_d;
    logic             start_q;
    logic             dot_q, dot_d;
    logic             new_bit_q, new_bit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_rise;
    logic [NBITS-1:0] code;

    assign start_rise = Start & ~start_q;

    // Left-justified, MSB-first Morse patterns.
    always_comb begin
        code = '0;
        case (Letter)
            3'd0: code = 12'b1011_1000_0000; // A
            3'd1: code = 12'b1110_1010_1000; // B
            3'd2: code = 12'b1110_1011_1010; // C
            3'd3: code = 12'b1110_1010_0000; // D
            3'd4: code = 12'b1000_0000_0000; // E
            3'd5: code = 12'b1010_1110_1000; // F
            3'd6: code = 12'b1110_1110_1000; // G
            3'd7: code = 12'b1010_1010_0000; // H
            default: code = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        rate_d    = rate_q;
        bit_d     = bit_q;
        new_bit_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_rise) begin
                    shreg_d   = code;
                    rate_d    = RateMax;
                    bit_d     = 4'd0;
                    new_bit_d = 1'b1;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (rate_q != '0) begin
                    rate_d = rate_q - RateW'(1);
                end else if (bit_q != LastBit) begin
                    shreg_d   = {shreg_q[NBITS-2:0], 1'b0};
                    bit_d     = bit_q + 4'd1;
                    rate_d    = RateMax;
                    new_bit_d = 1'b1;
                end else begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Outputs are registered from next-state so they line up with the FSM.
        dot_d  = (state_d == StSend) & shreg_d[NBITS-1];
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            rate_q    <= '0;
            bit_q     <= '0;
            start_q   <= 1'b0;
            dot_q     <= 1'b0;
            new_bit_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            rate_q    <= rate_d;
            bit_q     <= bit_d;
            start_q   <= Start;
            dot_q     <= dot_d;
            new_bit_q <= new_bit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign DotDashOut = dot_q;
    assign NewBitOut  = new_bit_q;
    assign Busy       = busy_q;
    assign Done       = done_q;

endmodule
